// File: rtl/write_dac_pkg.sv
// Shared types and helpers for the dual-channel DAC playback writer.
package write_dac_pkg;

    localparam int DW = 14;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PRIME = 2'd1,
        RUN   = 2'd2
    } state_t;

    // Offset-binary line code to two's complement: flipping the MSB subtracts mid-scale.
    function automatic logic [DW-1:0] line_to_twos(input logic [DW-1:0] p);
        return {~p[DW-1], p[DW-2:0]};
    endfunction

endpackage

// File: rtl/write_dac_sample_fifo.sv
// Synchronous sample-pair FIFO with flush; pointers carry one extra wrap bit
// so that occupancy is a plain subtraction.
module sample_fifo #(
    parameter int WIDTH = 28,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (push && !flush) mem[wr_ptr[AW-1:0]] <= wdata;
    end

    assign rdata = mem[rd_ptr[AW-1:0]];
    assign level = wr_ptr - rd_ptr;

endmodule

// File: rtl/write_dac.sv
// Dual-channel DAC playback writer: buffers offset-binary pairs, then plays
// them out as two's-complement codes at a programmable update rate.
//
//   state | meaning
//   IDLE  | disabled, FIFO flushed, outputs parked at zero code
//   PRIME | accepting samples until the FIFO is full, no updates
//   RUN   | divider ticking, one pair popped per tick
module write_dac #(
    parameter int DW    = write_dac_pkg::DW,
    parameter int DEPTH = 4,
    parameter int DIV_W = 16
) (
    input  logic                    CLK_P,
    input  logic                    RESET_N,
    input  logic                    EN,
    input  logic [DIV_W-1:0]        RATE_DIV,
    input  logic                    IN_VALID,
    output logic                    IN_READY,
    input  logic [DW-1:0]           IN_A,
    input  logic [DW-1:0]           IN_B,
    output logic [DW-1:0]           DAC_A,
    output logic [DW-1:0]           DAC_B,
    output logic                    DAC_WR,
    output logic                    UNDERRUN,
    input  logic                    CLR_UNDERRUN,
    output logic [$clog2(DEPTH):0]  LEVEL
);

    import write_dac_pkg::*;

    localparam int LW = $clog2(DEPTH) + 1;
    localparam logic [LW-1:0]    FULL_LVL = LW'(DEPTH);
    localparam logic [DIV_W-1:0] DIV_ONE  = {{(DIV_W-1){1'b0}}, 1'b1};

    state_t            state;
    state_t            state_nxt;
    logic [DIV_W-1:0]  div_cnt;
    logic [DIV_W-1:0]  div_reload;
    logic              tick;
    logic              pop;
    logic              push;
    logic              flush;
    logic              underrun_tick;
    logic [2*DW-1:0]   head;

    sample_fifo #(
        .WIDTH (2*DW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (CLK_P),
        .rst_n (RESET_N),
        .push  (push),
        .pop   (pop),
        .flush (flush),
        .wdata ({IN_A, IN_B}),
        .rdata (head),
        .level (LEVEL)
    );

    always_ff @(posedge CLK_P or negedge RESET_N) begin
        if (!RESET_N) state <= IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (!EN) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE:    state_nxt = PRIME;
                PRIME:   if (LEVEL == FULL_LVL) state_nxt = RUN;
                RUN:     if (underrun_tick) state_nxt = PRIME;
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_comb begin
        IN_READY      = EN && (state != IDLE) && (LEVEL < FULL_LVL);
        tick          = EN && (state == RUN) && (div_cnt == '0);
        pop           = tick && (LEVEL != '0);
        underrun_tick = tick && (LEVEL == '0);
        push          = IN_VALID && IN_READY;
        flush         = !EN || (state == IDLE);
    end

    // Zero is treated as one, so the divider never stalls.
    assign div_reload = (RATE_DIV == '0) ? '0 : RATE_DIV - DIV_ONE;

    always_ff @(posedge CLK_P or negedge RESET_N) begin
        if (!RESET_N)                  div_cnt <= '0;
        else if (!EN || state != RUN)  div_cnt <= '0;
        else if (tick)                 div_cnt <= div_reload;
        else                           div_cnt <= div_cnt - DIV_ONE;
    end

    always_ff @(posedge CLK_P or negedge RESET_N) begin
        if (!RESET_N) begin
            DAC_A  <= '0;
            DAC_B  <= '0;
            DAC_WR <= 1'b0;
        end else if (!EN) begin
            DAC_A  <= '0;
            DAC_B  <= '0;
            DAC_WR <= 1'b0;
        end else if (pop) begin
            DAC_A  <= line_to_twos(head[2*DW-1:DW]);
            DAC_B  <= line_to_twos(head[DW-1:0]);
            DAC_WR <= 1'b1;
        end else begin
            // An underrun tick still strobes, re-presenting the held codes.
            DAC_WR <= underrun_tick;
        end
    end

    always_ff @(posedge CLK_P or negedge RESET_N) begin
        if (!RESET_N)          UNDERRUN <= 1'b0;
        else if (underrun_tick) UNDERRUN <= 1'b1;
        else if (CLR_UNDERRUN)  UNDERRUN <= 1'b0;
    end

endmodule

// File: tb/tb_write_dac.sv
// Directed and randomized bench for write_dac against a queue-based playback model.
module tb_write_dac;

    localparam int M_IDLE  = 0;
    localparam int M_PRIME = 1;
    localparam int M_RUN   = 2;

    logic        CLK_P = 1'b0;
    logic        RESET_N;
    logic        EN;
    logic [15:0] RATE_DIV;
    logic        IN_VALID;
    logic        IN_READY;
    logic [13:0] IN_A;
    logic [13:0] IN_B;
    logic [13:0] DAC_A;
    logic [13:0] DAC_B;
    logic        DAC_WR;
    logic        UNDERRUN;
    logic        CLR_UNDERRUN;
    logic [2:0]  LEVEL;

    int n_cmp = 0;
    int n_bad = 0;

    // Playback model: a queue of pending pairs and the absolute cycle of the next update.
    int          mode;
    int          cyc;
    int          next_tick;
    logic [13:0] qa[$];
    logic [13:0] qb[$];
    logic [13:0] e_a;
    logic [13:0] e_b;
    logic        e_wr;
    logic        e_un;

    logic [13:0] cap[$];

    write_dac #(.DW(14), .DEPTH(4), .DIV_W(16)) dut (
        .CLK_P        (CLK_P),
        .RESET_N      (RESET_N),
        .EN           (EN),
        .RATE_DIV     (RATE_DIV),
        .IN_VALID     (IN_VALID),
        .IN_READY     (IN_READY),
        .IN_A         (IN_A),
        .IN_B         (IN_B),
        .DAC_A        (DAC_A),
        .DAC_B        (DAC_B),
        .DAC_WR       (DAC_WR),
        .UNDERRUN     (UNDERRUN),
        .CLR_UNDERRUN (CLR_UNDERRUN),
        .LEVEL        (LEVEL)
    );

    always #5 CLK_P = ~CLK_P;

    function automatic logic [13:0] to_twos(input logic [13:0] p);
        logic [13:0] r;
        r = p - 14'd8192;
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        mode = M_IDLE;
        qa.delete();
        qb.delete();
        e_a  = '0;
        e_b  = '0;
        e_wr = 1'b0;
        e_un = 1'b0;
    endtask

    function automatic logic will_underrun(input logic en);
        return en && mode == M_RUN && cyc == next_tick && qa.size() == 0;
    endfunction

    task automatic step(input logic en, input logic valid, input logic [13:0] a,
                        input logic [13:0] b, input logic [15:0] rate, input logic clr);
        logic exp_ready;
        logic push;
        logic set_un;
        EN = en; IN_VALID = valid; IN_A = a; IN_B = b; RATE_DIV = rate; CLR_UNDERRUN = clr;
        #1;
        exp_ready = en && mode != M_IDLE && qa.size() < 4;
        chk("in_ready", IN_READY, exp_ready);
        push   = valid && exp_ready;
        set_un = 1'b0;
        if (!en) begin
            mode = M_IDLE;
            qa.delete();
            qb.delete();
            e_a  = '0;
            e_b  = '0;
            e_wr = 1'b0;
            if (clr) e_un = 1'b0;
        end else begin
            e_wr = 1'b0;
            case (mode)
                M_IDLE:  mode = M_PRIME;
                M_PRIME: if (qa.size() == 4) begin
                    mode = M_RUN;
                    next_tick = cyc + 1;
                end
                default: if (cyc == next_tick) begin
                    next_tick = cyc + ((rate == 0) ? 1 : int'(rate));
                    e_wr = 1'b1;
                    if (qa.size() > 0) begin
                        e_a = to_twos(qa.pop_front());
                        e_b = to_twos(qb.pop_front());
                    end else begin
                        set_un = 1'b1;
                        mode = M_PRIME;
                    end
                end
            endcase
            if (push) begin
                qa.push_back(a);
                qb.push_back(b);
            end
            if (set_un)   e_un = 1'b1;
            else if (clr) e_un = 1'b0;
        end
        cyc++;
        @(posedge CLK_P);
        #1;
        chk("dac_a", DAC_A, e_a);
        chk("dac_b", DAC_B, e_b);
        chk("dac_wr", DAC_WR, e_wr);
        chk("underrun", UNDERRUN, e_un);
        chk("level", LEVEL, qa.size());
    endtask

    initial begin
        logic [13:0] play_a[4];
        logic [13:0] want_a[5];
        logic        found;

        play_a[0] = 14'h2000; play_a[1] = 14'h3FFF; play_a[2] = 14'h0000; play_a[3] = 14'h2001;
        want_a[0] = 14'h0000; want_a[1] = 14'h1FFF; want_a[2] = 14'h2000; want_a[3] = 14'h0001;
        want_a[4] = 14'h0001;

        RESET_N = 1'b0; EN = 1'b0; IN_VALID = 1'b0; IN_A = '0; IN_B = '0;
        RATE_DIV = '0; CLR_UNDERRUN = 1'b0;
        cyc = 0; next_tick = 0;
        model_reset();
        repeat (2) @(posedge CLK_P);
        #1;
        chk("rst_dac_a", DAC_A, 0);
        chk("rst_dac_wr", DAC_WR, 0);
        chk("rst_in_ready", IN_READY, 0);
        chk("rst_level", LEVEL, 0);
        RESET_N = 1'b1;

        // Prime with the reference line codes, then starve until underrun.
        step(1, 0, '0, '0, 16'd4, 0);
        for (int i = 0; i < 4; i++) step(1, 1, play_a[i], 14'($urandom), 16'd4, 0);
        for (int i = 0; i < 26; i++) begin
            step(1, 0, '0, '0, 16'd4, will_underrun(1'b1));
            if (DAC_WR) cap.push_back(DAC_A);
        end
        chk("play_strobes", cap.size(), 5);
        for (int i = 0; i < 5 && i < cap.size(); i++) chk("play_code", cap[i], want_a[i]);
        chk("underrun_set_wins", UNDERRUN, 1);
        step(1, 0, '0, '0, 16'd4, 1);

        // Backpressure: source always valid, slow update rate.
        for (int i = 0; i < 90; i++) step(1, 1, 14'($urandom), 14'($urandom), 16'd8, 0);

        // Starve down to two pending pairs, then disable.
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            if (mode == M_RUN && qa.size() == 2) found = 1'b1;
            else step(1, 0, '0, '0, 16'd4, 0);
        end
        chk("disable_setup", found, 1);
        step(0, 0, '0, '0, 16'd4, 0);
        chk("disable_level", LEVEL, 0);
        for (int i = 0; i < 3; i++) step(1, 1, 14'($urandom), 14'($urandom), 16'd4, 0);
        for (int i = 0; i < 6; i++) step(1, 0, '0, '0, 16'd4, 0);
        for (int i = 0; i < 8; i++) step(1, 1, 14'($urandom), 14'($urandom), 16'd2, 0);

        // Underrun again, re-prime, then reset asynchronously mid-run.
        for (int i = 0; i < 20; i++) step(1, 0, '0, '0, 16'd2, 0);
        for (int i = 0; i < 4; i++) step(1, 1, 14'($urandom_range(0, 16'h1FFF)), 14'($urandom), 16'd3, 0);
        for (int i = 0; i < 3; i++) step(1, 0, '0, '0, 16'd3, 0);
        chk("pre_reset_underrun", UNDERRUN, 1);
        #2;
        RESET_N = 1'b0;
        #1;
        chk("arst_dac_a", DAC_A, 0);
        chk("arst_dac_b", DAC_B, 0);
        chk("arst_dac_wr", DAC_WR, 0);
        chk("arst_underrun", UNDERRUN, 0);
        chk("arst_level", LEVEL, 0);
        chk("arst_in_ready", IN_READY, 0);
        @(posedge CLK_P);
        #1;
        RESET_N = 1'b1;
        model_reset();

        // Full rate: update every cycle while the source streams.
        for (int i = 0; i < 40; i++) step(1, 1, 14'($urandom), 14'($urandom), 16'd0, 0);
        for (int i = 0; i < 10; i++) step(1, 1, 14'($urandom), 14'($urandom), 16'd1, 0);

        // Random mix of enables, rates, gaps and clears.
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 31) != 0, $urandom_range(0, 3) != 0,
                 14'($urandom), 14'($urandom), 16'($urandom_range(0, 5)),
                 $urandom_range(0, 7) == 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/write_dac.md
# write_dac

Dual-channel DAC playback writer: the transmit-side counterpart of the dual-ADC capture path. Accepts paired 14-bit offset-binary ("line") samples through a valid/ready handshake and buffers them in a small FIFO. Converts them to two's-complement DAC codes and drives both DAC channels at a programmable update rate. Flags buffer underrun and parks the outputs at mid-scale when disabled.

## Interface
- DW, 14, sample width per channel
- DEPTH, 4, FIFO depth in sample pairs (power of two, ≥2)
- DIV_W, 16, width of rate divider

- CLK_P  in  1  sample clock; all logic on rising edge
- RESET_N  in  1  asynchronous, active-low reset
- EN  in  1  playback enable; low = idle, flush, mid-scale output
- RATE_DIV  in  DIV_W  update period in CLK_P cycles; 0 treated as 1
- IN_VALID  in  1  IN_A/IN_B hold a valid sample pair
- IN_READY  out  1  block accepts pair this cycle
- IN_A, IN_B  in  DW  offset-binary samples (14'h2000 = zero)
- DAC_A, DAC_B  out  DW  two's-complement DAC codes, registered
- DAC_WR  out  1  one-cycle strobe, DAC_A/B updated this cycle
- UNDERRUN  out  1  sticky underrun flag
- CLR_UNDERRUN  in  1  clears UNDERRUN
- LEVEL  out  clog2(DEPTH)+1  FIFO occupancy

## Operation
- Reset: state IDLE, FIFO empty, DAC_A=DAC_B=0, DAC_WR=0, UNDERRUN=0, IN_READY=0, LEVEL=0, divider counter 0.
- Conversion: DAC_x = {~P[DW-1], P[DW-2:0]} (MSB invert); 14'h2000→0, 14'h3FFF→14'h1FFF, 14'h0000→14'h2000.
- Push when IN_VALID && IN_READY. IN_READY = EN && (state≠IDLE) && (LEVEL<DEPTH). Push and pop in same cycle legal; LEVEL unchanged.
- States:
  - IDLE: FIFO flushed, outputs 0. EN=1 → PRIME.
  - PRIME: accept pushes, no ticks. LEVEL==DEPTH → RUN, divider counter loaded with 0.
  - RUN: counter==0 is a tick; counter reloads max(RATE_DIV,1)-1 on tick, else decrements. RATE_DIV sampled only at reload.
- Tick with LEVEL>0: pop head, convert, register to DAC_A/B, DAC_WR=1 next cycle.
- Tick with LEVEL==0 (underrun): DAC_A/B hold previous value, DAC_WR still pulses, UNDERRUN←1, state → PRIME.
- EN=0 in any state: next cycle IDLE, FIFO flushed, DAC_A/B←0, DAC_WR=0; pending tick discarded. UNDERRUN unaffected.
- UNDERRUN: set on underrun tick; cleared by CLR_UNDERRUN; set wins if both in same cycle.
- Async reset mid-playback: all outputs to reset values immediately, no strobe.

## Timing
- Tick at cycle t → DAC_A/B new value and DAC_WR high at t+1 (1-cycle latency from pop).
- First tick in first RUN cycle; thereafter every max(RATE_DIV,1) cycles; RATE_DIV=0/1 → DAC_WR every cycle.
- LEVEL reflects pushes/pops registered at end of cycle.
- IN_READY combinational from registered state/LEVEL only; no path from IN_VALID.
- Full FIFO: IN_READY low same cycle LEVEL reaches DEPTH; rises cycle after pop.
- Sustained throughput: one pair per tick when source keeps IN_VALID high.

## Structure
- Package write_dac_pkg: DW, state enum {IDLE, PRIME, RUN}, function line_to_twos(P).
- Sub-module sample_fifo: synchronous FIFO, DEPTH × 2·DW, push/pop/flush, LEVEL output, wrap-around pointers with extra bit for full/empty.
- Top holds FSM, divider, conversion/output registers, UNDERRUN flag.

## Test plan
- Reset: RESET_N low mid-RUN → DAC_A/B=0, DAC_WR=0, UNDERRUN=0, LEVEL=0, IN_READY=0 immediately.
- Prime and play: EN=1, RATE_DIV=4, push 2000,3FFF,0000,2001 (A) → state RUN at LEVEL=4; DAC_A = 0000,1FFF,2000,0001 with DAC_WR spaced exactly 4 cycles.
- Backpressure: hold IN_VALID high with RATE_DIV=8 → IN_READY low while LEVEL=4, exactly one push per DAC_WR, no sample lost or duplicated.
- Underrun: stop pushes after priming → fifth tick holds last DAC_A, DAC_WR pulses, UNDERRUN=1, state PRIME; CLR_UNDERRUN same cycle as underrun → UNDERRUN stays 1.
- Disable mid-run: EN=0 with LEVEL=2 → next cycle DAC_A/B=0, LEVEL=0, no DAC_WR; EN=1 requires re-priming to 4.
- RATE_DIV=0 → DAC_WR every cycle while FIFO fed at full rate; simultaneous push/pop keeps LEVEL constant.
